trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 43 ++++
 rtl/trap_csr_file.sv | 102 ++++++++++
 rtl/trap_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Purpose: shared types for the trap controller (exception causes, FSM states, CSR map).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro used by this slice: TRAP_MTVAL_EN (mtval CSR present).
package trap_ctrl_pkg;

  typedef logic [31:0] gpreg;

  // Machine-mode exception cause codes; the encoding is the mcause value.
  typedef enum logic [3:0] {
    EX_INSTR_MISALIGN = 4'd0,
    EX_INSTR_FAULT    = 4'd1,
    EX_ILLEGAL_INSTR  = 4'd2,
    EX_BREAKPOINT     = 4'd3,
    EX_LOAD_MISALIGN  = 4'd4,
    EX_LOAD_FAULT     = 4'd5,
    EX_STORE_MISALIGN = 4'd6,
    EX_STORE_FAULT    = 4'd7,
    EX_ECALL_U        = 4'd8,
    EX_ECALL_M        = 4'd11
  } ex_type;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Word-align an address (clear bits [1:0]).
  function automatic gpreg align4(gpreg v);
    return v & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Purpose: machine trap CSRs (mstatus MIE/MPIE, mtvec, mepc, mcause, mtval) with combinational read mux.
// Latency: writes and trap/MRET updates visible the cycle after the strobe; reads are combinational.
// Backpressure: none; the owner gates i_wr_en/i_trap/i_mret, trap and MRET take priority over writes.
// Ports: clk/rst; i_wr_en,i_addr,i_wdata -> o_rdata (CSR port); i_trap,i_trap_pc,i_trap_cause,
//        i_trap_tval (trap entry); i_mret (return); o_mtvec,o_mepc (redirect sources).
// Config: TRAP_MTVAL_EN adds the mtval register; without it 0x343 reads 0 and writes are dropped.
module trap_csr_file
  import trap_ctrl_pkg::*;
#(
  parameter gpreg RESET_MTVEC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [11:0] i_addr,
  input  gpreg        i_wdata,
  output gpreg        o_rdata,
  input  logic        i_trap,
  input  logic        i_mret,
  input  gpreg        i_trap_pc,
  input  ex_type      i_trap_cause,
  input  gpreg        i_trap_tval,
  output gpreg        o_mtvec,
  output gpreg        o_mepc
);

  gpreg r_mtvec;
  gpreg r_mepc;
  gpreg r_mcause;
  logic r_mie;
  logic r_mpie;
  gpreg w_mtval;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtvec  <= RESET_MTVEC;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else if (i_trap) begin
      r_mepc   <= align4(i_trap_pc);
      r_mcause <= {28'd0, i_trap_cause};
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (i_mret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (i_wr_en) begin
      case (i_addr)
        CSR_MSTATUS: begin
          r_mie  <= i_wdata[MSTATUS_MIE];
          r_mpie <= i_wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:  r_mtvec  <= align4(i_wdata);
        CSR_MEPC:   r_mepc   <= align4(i_wdata);
        CSR_MCAUSE: r_mcause <= i_wdata;
        default: ;
      endcase
    end
  end

`ifdef TRAP_MTVAL_EN
  gpreg r_mtval;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtval <= '0;
    end else if (i_trap) begin
      r_mtval <= i_trap_tval;
    end else if (i_wr_en && !i_mret && (i_addr == CSR_MTVAL)) begin
      r_mtval <= i_wdata;
    end
  end

  assign w_mtval = r_mtval;
`else
  // No storage: trap value is discarded.
  logic w_unused_tval;
  assign w_unused_tval = ^i_trap_tval;
  assign w_mtval       = '0;
`endif

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CSR_MSTATUS: begin
        o_rdata[MSTATUS_MIE]  = r_mie;
        o_rdata[MSTATUS_MPIE] = r_mpie;
      end
      CSR_MTVEC:  o_rdata = r_mtvec;
      CSR_MEPC:   o_rdata = r_mepc;
      CSR_MCAUSE: o_rdata = r_mcause;
      CSR_MTVAL:  o_rdata = w_mtval;
      default:    o_rdata = '0;
    endcase
  end

  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

endmodule

// File: rtl/trap_ctrl.sv
// Purpose: trap/MRET sequencer: accept at commit, flush the pipe, update CSRs, one-cycle fetch redirect.
// Latency: accept -> FLUSH next cycle; redirect one cycle after drain_done; minimum 3 cycles per trap.
// Backpressure: commit_ready is low in FLUSH and REDIRECT; ordinary commits retire freely in IDLE.
// Ports: clk/rst; commit_* (retire + exception/MRET info); drain_done (pipe empty);
//        flush, redirect_valid/redirect_target (to front end); csr_we/addr/wdata/rdata (CSR port).
// Config: TRAP_MTVAL_EN enables the mtval CSR inside trap_csr_file.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter gpreg RESET_MTVEC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_ex_valid,
  input  ex_type      commit_ex,
  input  gpreg        commit_ex_tval,
  input  logic        commit_ret_valid,
  input  logic        drain_done,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_target,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata
);

  trap_state_e r_state;
  trap_state_e w_state_nxt;

  gpreg   r_pc;
  gpreg   r_tval;
  ex_type r_cause;
  logic   r_is_trap;   // 1: exception, 0: MRET

  logic w_accept;
  logic w_apply;
  logic w_trap;
  logic w_mret;
  logic w_csr_wr;
  gpreg w_mtvec;
  gpreg w_mepc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_tval    <= '0;
      r_cause   <= EX_INSTR_MISALIGN;
      r_is_trap <= 1'b0;
    end else if (w_accept) begin
      r_pc      <= commit_pc;
      r_tval    <= commit_ex_tval;
      r_cause   <= commit_ex;
      // Exception beats MRET when both are flagged.
      r_is_trap <= commit_ex_valid;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    commit_ready   = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    w_accept       = 1'b0;
    w_apply        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        commit_ready = 1'b1;
        if (commit_valid && (commit_ex_valid || commit_ret_valid)) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (drain_done) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // CSR side effects land on the FLUSH->REDIRECT edge; rst in the same cycle
  // wins inside the CSR file, so an aborted sequence leaves only reset values.
  assign w_trap   = w_apply &  r_is_trap;
  assign w_mret   = w_apply & ~r_is_trap;
  assign w_csr_wr = csr_we & (r_state == ST_IDLE) & ~w_accept;

  // mtvec is aligned here too since RESET_MTVEC may carry low bits.
  assign redirect_target = redirect_valid ? (r_is_trap ? align4(w_mtvec) : w_mepc) : '0;

  trap_csr_file #(
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_csr_wr),
    .i_addr       (csr_addr),
    .i_wdata      (csr_wdata),
    .o_rdata      (csr_rdata),
    .i_trap       (w_trap),
    .i_mret       (w_mret),
    .i_trap_pc    (r_pc),
    .i_trap_cause (r_cause),
    .i_trap_tval  (r_tval),
    .o_mtvec      (w_mtvec),
    .o_mepc       (w_mepc)
  );

endmodule
